// File: rtl/bypass_sel_ctrl.sv
// Operand-bypass select controller for one source operand of a four-issue pipeline.
// Optional feature macro: BYPASS_LOAD_FWD_EN (forward M-stage load data as select 9).
module bypass_sel_ctrl #(
  parameter int REGW = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   adv,
  input  logic                   flush,
  input  logic [3:0]             id_we,
  input  logic [4*REGW-1:0]      id_rd,
  input  logic [3:0]             id_isload,
  input  logic                   id_hilo_we,
  input  logic [REGW-1:0]        rs,
  input  logic                   rs_hilo,
  output logic [3:0]             sel,
  output logic                   load_use
);

  // Issue width is tied to the select encoding, so it is not a parameter.
  localparam int NSLOT = 4;

  localparam logic [3:0] SEL_RF   = 4'd0;
  localparam logic [3:0] SEL_E0   = 4'd1;
  localparam logic [3:0] SEL_M0   = 4'd5;
  localparam logic [3:0] SEL_MLD  = 4'd9;
  localparam logic [3:0] SEL_HILO = 4'd10;

  logic [NSLOT-1:0]      e_we, m_we;
  logic [NSLOT*REGW-1:0] e_rd, m_rd;
  logic [NSLOT-1:0]      e_isload, m_isload;
  logic                  e_hilo, m_hilo;

  logic       e_hit, m_hit;
  logic [1:0] e_slot, m_slot;
  logic [3:0] sel_d;
  logic       lu_d;

  // Ascending scan so the highest matching slot (latest in program order) wins.
  always_comb begin
    e_hit  = 1'b0;
    e_slot = 2'd0;
    m_hit  = 1'b0;
    m_slot = 2'd0;
    for (int s = 0; s < NSLOT; s++) begin
      if (e_we[s] && (e_rd[s*REGW +: REGW] == rs)) begin
        e_hit  = 1'b1;
        e_slot = 2'(s);
      end
      if (m_we[s] && (m_rd[s*REGW +: REGW] == rs)) begin
        m_hit  = 1'b1;
        m_slot = 2'(s);
      end
    end
  end

  always_comb begin
    sel_d = SEL_RF;
    lu_d  = 1'b0;
    if (rs_hilo) begin
      if (e_hilo || m_hilo) sel_d = SEL_HILO;
    end else if (rs != '0) begin
      if (e_hit) begin
        if (e_isload[e_slot]) lu_d  = 1'b1;
        else                  sel_d = SEL_E0 + {2'b00, e_slot};
      end else if (m_hit) begin
        if (m_isload[m_slot]) begin
`ifdef BYPASS_LOAD_FWD_EN
          sel_d = SEL_MLD;
`else
          lu_d  = 1'b1;
`endif
        end else begin
          sel_d = SEL_M0 + {2'b00, m_slot};
        end
      end
    end
  end

  assign load_use = lu_d;

  // Flush kills in-flight writers but keeps stale rd/isload; they are gated by we.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_we     <= '0;
      m_we     <= '0;
      e_rd     <= '0;
      m_rd     <= '0;
      e_isload <= '0;
      m_isload <= '0;
      e_hilo   <= 1'b0;
      m_hilo   <= 1'b0;
      sel      <= SEL_RF;
    end else if (flush) begin
      e_we   <= '0;
      m_we   <= '0;
      e_hilo <= 1'b0;
      m_hilo <= 1'b0;
      sel    <= SEL_RF;
    end else if (adv) begin
      sel      <= sel_d;
      m_we     <= e_we;
      m_rd     <= e_rd;
      m_isload <= e_isload;
      m_hilo   <= e_hilo;
      e_we     <= id_we;
      e_rd     <= id_rd;
      e_isload <= id_isload;
      e_hilo   <= id_hilo_we;
    end
  end

endmodule

// File: doc/bypass_sel_ctrl.md
# bypass_sel_ctrl

Operand-bypass select controller for one source operand of the four-issue pipeline. Tracks destination tags of the two bundles ahead of decode and, on each pipeline advance, registers the 4-bit select that drives the downstream 11-way operand mux. Also flags load-use hazards to the stall logic. One instance per source operand; eight instances per core.

## Interface
- REGW, 5: register index width
- NSLOT, 4: issue width; fixed at 4 and not overridable, because the mux select encoding depends on it
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- adv  in  1  pipeline advance; tracker and sel update only when 1
- flush  in  1  kill all in-flight bundles (branch mispredict / exception)
- id_we  in  NSLOT  per-slot register write enable of decode bundle
- id_rd  in  NSLOT*REGW  per-slot destination register; slot s at [s*REGW +: REGW]
- id_isload  in  NSLOT  per-slot load flag; at most one set per bundle
- id_hilo_we  in  1  decode bundle writes HI/LO
- rs  in  REGW  queried source register of this operand in the decode bundle
- rs_hilo  in  1  operand reads HI/LO (mfhi/mflo); rs ignored when set
- sel  out  4  registered mux select
- load_use  out  1  combinational load-use hazard

## Operation
- State:
  - E tracker: one bundle older than decode, holding we[3:0], rd, isload, hilo_we.
  - M tracker: two bundles older than decode, same fields.
  - sel_q.
- Select encoding:
  - 0: register file or HI/LO register file.
  - 1..4: E-bundle ALU result, slots 0..3.
  - 5..8: M-bundle ALU result, slots 0..3.
  - 9: M-stage load data.
  - 10: in-flight HI/LO.
  - 11..15: never produced.
- Select function f, evaluated from pre-edge state:
  - If rs_hilo=1: 10 if E.hilo_we or M.hilo_we, else 0.
  - Else if rs=0: 0. Register 0 is never forwarded.
  - Else take the youngest match. E beats M. Within a bundle the highest slot index beats lower ones (later in program order). A slot matches when we[s]=1 and rd[s]=rs.
    - E match at slot s, non-load: sel = 1+s.
    - E match at slot s, load: load_use=1 and sel = 0.
    - M match at slot s, non-load: 5+s.
    - M match at slot s, load: 9.
    - No match: 0.
- load_use = rs_hilo=0 AND rs≠0 AND the youngest match is a load in E. It depends only on current inputs and state.
- On an edge with adv=1 and flush=0: sel_q ← f; M ← E; E ← decode bundle.
- On an edge with adv=0 and flush=0: all state holds.
- On an edge with flush=1: E.we, M.we, E.hilo_we and M.hilo_we clear; sel_q ← 0. Flush wins over a simultaneous adv; the decode bundle is not captured.
- Intra-bundle RAW dependences are excluded by issue logic and are not handled here.

## Timing
- Reset: sel=0, load_use=0 (trackers empty), all tracker valid bits 0.
- Latency: sel is valid in the cycle after the adv edge, aligned with the operand's bundle arriving at the mux stage.
- load_use is zero-latency and combinational. Stall logic must deassert adv while it is 1. If adv=1 regardless, sel_q ← 0.
- Reset asserted mid-operation has the same effect as flush, plus it clears all remaining state.

## Configuration
- BYPASS_LOAD_FWD_EN defined:
  - A load match in M yields sel=9.
  - load_use is asserted only for a load match in E.
- BYPASS_LOAD_FWD_EN undefined:
  - A load match in M also asserts load_use, with sel=0 if adv.
  - Encoding 9 is never produced.

## Test plan
- Reset, then adv=1 with an empty tracker and rs=7 -> sel=0, load_use=0.
- Bundle A with slot2 writing r5 (non-load), adv; then rs=5, adv -> sel=3. Repeat with one intervening empty bundle -> sel=7.
- E slot1 and M slot3 both write r9, plus E slot3 writes r9 -> rs=9 gives sel=4 (youngest bundle, highest slot).
- E slot0 load r4, rs=4 -> load_use=1. Hold adv=0 for 1 cycle, then adv twice -> sel=9 with the define, or load_use=1 held one more cycle without it.
- rs_hilo=1 with M.hilo_we=1 -> sel=10. Same with rs=0 and we on r0 -> sel=0.
- E slot1 writes r6 with flush and adv together, then rs=6, adv -> sel=0, and no later stage match remains.
